// File: rtl/batrider_snd_bridge.sv
// 68000 -> Batrider sound command bridge: queued SOUNDLATCH/2 delivery with NMI ack handshake,
// SOUNDLATCH3/4 + status read-back, latched host IRQ. Optional ack timeout: BATRIDER_SNDBRIDGE_TIMEOUT_EN.
module batrider_snd_bridge #(
  parameter int FIFO_AW     = 2,
  parameter int CS_LEN      = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic       CLK96,
  input  logic       RESET96,
  input  logic       M68_WR,
  input  logic       M68_RD,
  input  logic [1:0] M68_ADDR,
  input  logic [7:0] M68_DIN,
  output logic [7:0] M68_DOUT,
  output logic       M68_FULL,
  output logic       M68_IRQ,
  output logic [7:0] SOUNDLATCH,
  output logic [7:0] SOUNDLATCH2,
  output logic       SND_CS,
  input  logic       SND_WAIT,
  input  logic [7:0] SOUNDLATCH3,
  input  logic [7:0] SOUNDLATCH4,
  input  logic       SNDIRQ
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int CSW   = $clog2(CS_LEN);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CSW-1:0] CS_LAST = CSW'(CS_LEN - 1);

  if (FIFO_AW < 1 || FIFO_AW > 3 || CS_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("batrider_snd_bridge: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_ACK_HI, S_ACK_LO} state_t;

  state_t             state, state_next;
  logic [7:0]         stage1;
  logic [15:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_next;
  logic [CSW-1:0]     cs_cnt;
  logic               wr_stb, push_ok, pop, cs_d, busy;
  logic               stat_rd, ovf, ovf_set, tmo, to_hit;
  logic               irq_s1, irq_s2, irq_s3, irq_rise;

  assign wr_stb  = M68_WR && (M68_ADDR == 2'd1);
  assign push_ok = wr_stb && (count != DEPTH_C);
  assign ovf_set = wr_stb && (count == DEPTH_C);
  assign stat_rd = M68_RD && (M68_ADDR == 2'd0);

  // ---------------- delivery FSM ----------------
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) state <= S_IDLE;
    else         state <= state_next;
  end

  // A push in the same cycle is enough to leave IDLE, so LOAD follows the push directly.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if ((count != '0 || push_ok) && !SND_WAIT) state_next = S_LOAD;
      S_LOAD:   state_next = S_STROBE;
      S_STROBE: if (cs_cnt == CS_LAST) state_next = S_ACK_HI;
      S_ACK_HI: if (SND_WAIT)  state_next = S_ACK_LO;
      S_ACK_LO: if (!SND_WAIT) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (to_hit) state_next = S_IDLE;
  end

  always_comb begin
    pop  = (state == S_LOAD);
    cs_d = (state == S_STROBE);
    busy = (state != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      cs_cnt      <= '0;
      SND_CS      <= 1'b0;
      SOUNDLATCH  <= 8'h00;
      SOUNDLATCH2 <= 8'h00;
    end else begin
      cs_cnt <= (state == S_STROBE) ? cs_cnt + 1'b1 : '0;
      SND_CS <= cs_d;
      if (pop) {SOUNDLATCH, SOUNDLATCH2} <= fifo_mem[rd_ptr];
    end
  end

  // ---------------- command FIFO ----------------
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: FIFO storage has no reset; emptiness is defined by count/pointers alone.
  always_ff @(posedge CLK96) begin
    if (push_ok) fifo_mem[wr_ptr] <= {stage1, M68_DIN};
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      M68_FULL <= 1'b0;
      stage1   <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      M68_FULL <= (count_next == DEPTH_C);
      if (M68_WR && M68_ADDR == 2'd0) stage1 <= M68_DIN;
    end
  end

  // ---------------- host interrupt and sticky flags ----------------
  assign irq_rise = irq_s2 && !irq_s3;

  // Sets take priority over a coincident status-read clear.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      {irq_s1, irq_s2, irq_s3} <= 3'b000;
      M68_IRQ <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      {irq_s1, irq_s2, irq_s3} <= {SNDIRQ, irq_s1, irq_s2};
      if (irq_rise)     M68_IRQ <= 1'b1;
      else if (stat_rd) M68_IRQ <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (stat_rd) ovf <= 1'b0;
    end
  end

`ifdef BATRIDER_SNDBRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt;
  logic          in_ack;

  assign in_ack = (state == S_ACK_HI) || (state == S_ACK_LO);
  assign to_hit = in_ack && (to_cnt == TO_LAST);

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      to_cnt <= '0;
      tmo    <= 1'b0;
    end else begin
      if (!in_ack || state_next != state) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;
      if (to_hit)       tmo <= 1'b1;
      else if (stat_rd) tmo <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
  assign tmo    = 1'b0;
`endif

  // ---------------- host read-back ----------------
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      M68_DOUT <= 8'h00;
    end else if (M68_RD) begin
      case (M68_ADDR)
        2'd0:    M68_DOUT <= {busy, M68_IRQ, ovf, tmo, 4'(count)};
        2'd1:    M68_DOUT <= stage1;
        2'd2:    M68_DOUT <= SOUNDLATCH3;
        default: M68_DOUT <= SOUNDLATCH4;
      endcase
    end
  end

endmodule
